// File: rtl/vm_pkg.sv
// Shared types and helpers for the multi-item vending controller.
package vm_pkg;

  typedef enum logic [2:0] {IDLE, CREDIT, VEND, CHANGE, REFUND} state_e;

  typedef enum logic [1:0] {COIN_NONE, COIN_NICKEL, COIN_DIME, COIN_QUARTER} coin_e;

  function automatic logic [4:0] coin_value(coin_e c);
    case (c)
      COIN_NICKEL:  return 5'd5;
      COIN_DIME:    return 5'd10;
      COIN_QUARTER: return 5'd25;
      default:      return 5'd0;
    endcase
  endfunction

  // Item idx costs (idx+1) price steps.
  function automatic int unsigned price(int unsigned idx, int unsigned step);
    return (idx + 1) * step;
  endfunction

endpackage

// File: rtl/vm_bin2dec.sv
// Combinational split of a cent balance into dollars and remaining cents.
module vm_bin2dec #(
  parameter int BAL_W = 10
) (
  input  logic [BAL_W-1:0] bal,
  output logic [7:0]       dollars,
  output logic [7:0]       cents
);

  logic [BAL_W-1:0] quo, rem;

  always_comb begin
    quo     = bal / BAL_W'(100);
    rem     = bal % BAL_W'(100);
    dollars = 8'(quo);
    cents   = 8'(rem);
  end

endmodule

// File: rtl/vm_multi.sv
// Multi-item vending controller: credit, per-item pricing, vend, change and refund.
// Optional per-item stock tracking is enabled by defining VM_INVENTORY_EN.
module vm_multi
  import vm_pkg::*;
#(
  parameter int NUM_ITEMS  = 4,
  parameter int PRICE_STEP = 10,
  parameter int MAX_BAL    = 500,
  parameter int BAL_W      = 10,
  parameter int STOCK_INIT = 3,
  parameter int STOCK_W    = 4,
  localparam int IW        = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 coin_valid,
  input  logic [1:0]           coin,
  input  logic                 sel_valid,
  input  logic [IW-1:0]        item,
  input  logic                 refund_req,
  output logic                 vend_valid,
  output logic [IW-1:0]        vend_item,
  output logic                 change_valid,
  output logic [BAL_W-1:0]     change_cents,
  output logic [7:0]           dollars,
  output logic [7:0]           cents,
  output logic                 busy,
  output logic                 coin_reject,
  output logic                 sel_reject,
  output logic [NUM_ITEMS-1:0] sold_out,
  output logic                 green,
  output logic                 red,
  output logic                 blue
);

  state_e           state_q, state_d;
  logic [BAL_W-1:0] bal_q, bal_d;
  logic [IW-1:0]    item_q, item_d;
  logic             crej_q, crej_d, srej_q, srej_d;

  logic             coin_nz, coin_ok, sel_ok;
  logic [BAL_W:0]   coin_sum, sel_price, vend_price, vend_rem;

  // Extra top bit keeps the overflow/underflow compares honest.
  assign coin_nz    = coin_valid && (coin != 2'd0);
  assign coin_sum   = {1'b0, bal_q} + (BAL_W+1)'(coin_value(coin_e'(coin)));
  assign coin_ok    = coin_sum <= (BAL_W+1)'(MAX_BAL);
  assign sel_price  = (BAL_W+1)'(price(32'(item), PRICE_STEP));
  assign vend_price = (BAL_W+1)'(price(32'(item_q), PRICE_STEP));
  assign vend_rem   = {1'b0, bal_q} - vend_price;
  assign sel_ok     = ({1'b0, item} < (IW+1)'(NUM_ITEMS)) && !sold_out[item] &&
                      ({1'b0, bal_q} >= sel_price);

  always_comb begin
    state_d = state_q;
    bal_d   = bal_q;
    item_d  = item_q;
    crej_d  = 1'b0;
    srej_d  = 1'b0;
    case (state_q)
      IDLE: begin
        srej_d = sel_valid;
        if (coin_nz) begin
          if (coin_ok) begin
            bal_d   = coin_sum[BAL_W-1:0];
            state_d = CREDIT;
          end else begin
            crej_d = 1'b1;
          end
        end
      end
      CREDIT: begin
        if (refund_req) begin
          state_d = REFUND;
          crej_d  = coin_nz;
        end else if (sel_valid) begin
          crej_d = coin_nz;
          if (sel_ok) begin
            item_d  = item;
            state_d = VEND;
          end else begin
            srej_d = 1'b1;
          end
        end else if (coin_nz) begin
          if (coin_ok) bal_d = coin_sum[BAL_W-1:0];
          else         crej_d = 1'b1;
        end
      end
      VEND: begin
        crej_d  = coin_nz;
        bal_d   = vend_rem[BAL_W-1:0];
        state_d = (vend_rem != '0) ? CHANGE : IDLE;
      end
      CHANGE, REFUND: begin
        crej_d  = coin_nz;
        bal_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      bal_q   <= '0;
      item_q  <= '0;
      crej_q  <= 1'b0;
      srej_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bal_q   <= bal_d;
      item_q  <= item_d;
      crej_q  <= crej_d;
      srej_q  <= srej_d;
    end
  end

`ifdef VM_INVENTORY_EN
  logic [NUM_ITEMS-1:0][STOCK_W-1:0] stock_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
    end else if (state_q == VEND && stock_q[item_q] != '0) begin
      stock_q[item_q] <= stock_q[item_q] - 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_sold
    assign sold_out[g] = (stock_q[g] == '0);
  end
`else
  logic unused_stock;
  assign unused_stock = ^{STOCK_W'(STOCK_INIT)};
  assign sold_out     = '0;
`endif

  vm_bin2dec #(.BAL_W(BAL_W)) u_bin2dec (
    .bal     (bal_q),
    .dollars (dollars),
    .cents   (cents)
  );

  assign vend_valid   = (state_q == VEND);
  assign vend_item    = vend_valid ? item_q : '0;
  assign change_valid = (state_q == CHANGE) || (state_q == REFUND);
  assign change_cents = change_valid ? bal_q : '0;
  assign busy         = vend_valid || change_valid;
  assign coin_reject  = crej_q;
  assign sel_reject   = srej_q;
  assign green        = vend_valid;
  assign red          = crej_q | srej_q;
  assign blue         = change_valid;

endmodule

// File: doc/vm_multi.md
Name: vm_multi

Overview:
- Parametrised multi-item vending-machine controller, successor to the single-price 2-bit `vm`.
- Accepts coins, holds a credit balance in cents and takes item selections with per-item pricing.
- Dispenses, returns change and refunds on request.
- Drives the dollars/cents display and the green/red/blue status LEDs at the top level of the vending subsystem.

Parameters:
NUM_ITEMS, 4, number of selectable items; item i costs (i+1)*PRICE_STEP cents
PRICE_STEP, 10, price increment in cents
MAX_BAL, 500, maximum credit in cents; coins that would exceed it are rejected
BAL_W, 10, balance/change width in bits; must hold MAX_BAL
STOCK_INIT, 3, initial stock per item (used only with VM_INVENTORY_EN)
STOCK_W, 4, stock counter width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
coin_valid  in  1  one-cycle coin-insert strobe
coin  in  2  coin code: 0 none, 1 nickel (5), 2 dime (10), 3 quarter (25)
sel_valid  in  1  one-cycle selection strobe
item  in  $clog2(NUM_ITEMS)  selected item index
refund_req  in  1  one-cycle refund request
vend_valid  out  1  dispense pulse
vend_item  out  $clog2(NUM_ITEMS)  item dispensed, valid with vend_valid
change_valid  out  1  change/refund pulse
change_cents  out  BAL_W  amount returned, valid with change_valid
dollars  out  8  balance / 100
cents  out  8  balance % 100
busy  out  1  high in VEND, CHANGE, REFUND
coin_reject  out  1  one-cycle pulse; the coin mechanism returns the coin
sel_reject  out  1  one-cycle pulse; selection refused
sold_out  out  NUM_ITEMS  per-item empty flags
green  out  1  equals vend_valid
red  out  1  coin_reject | sel_reject
blue  out  1  change_valid

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, balance=0.
  - All pulse outputs are 0; vend_item=0, change_cents=0, dollars=0, cents=0, sold_out=0.
- dollars/cents are combinational from the balance register, so they update one cycle after the event that changes the balance.
- States and transitions:
  - IDLE: a valid coin (code≠0) adds its value to balance and moves to CREDIT. sel_valid gives sel_reject. refund_req is a no-op.
  - CREDIT: priority when inputs coincide is refund_req > sel_valid > coin_valid; a coin arriving with a higher-priority request gets coin_reject and is not credited.
    - refund_req → REFUND.
    - sel_valid with balance ≥ price(item) → VEND; with balance < price(item) → sel_reject pulse, stay in CREDIT. An item index ≥ NUM_ITEMS gives sel_reject.
    - Coin with balance+value ≤ MAX_BAL → credited; with balance+value > MAX_BAL → coin_reject, balance unchanged.
    - Coin code 0 with coin_valid=1 is ignored, with no reject.
  - VEND (1 cycle):
    - vend_valid=1, vend_item=latched item, balance -= price.
    - Next state is CHANGE if the remainder is > 0, else IDLE.
  - CHANGE / REFUND (1 cycle):
    - change_valid=1, change_cents=balance, balance←0.
    - Next state IDLE.
- While busy=1: coins get coin_reject; sel_valid and refund_req are dropped silently.
- Latency: selection accepted at edge k → vend_valid during cycle k+1, change_valid during k+2.
- Arithmetic: coin add and price subtract are computed at BAL_W+1 bits for the overflow compare; balance never goes negative and never exceeds MAX_BAL.
- Reset asserted mid-VEND/CHANGE: all state is lost, and no change is issued after release.

Optional Feature:
- Macro: VM_INVENTORY_EN.
- Defined:
  - Per-item STOCK_W counters load STOCK_INIT on reset and decrement on vend_valid.
  - sold_out[i]=1 when stock[i]==0.
  - Selecting a sold-out item gives sel_reject and stays in CREDIT with balance unchanged.
- Undefined: unlimited stock, sold_out tied to 0, no counters synthesised.

Decomposition:
- Package vm_pkg holds:
  - the state enum (IDLE, CREDIT, VEND, CHANGE, REFUND);
  - the coin code enum and coin_value() function (5/10/25);
  - the price() function.
- Sub-module vm_bin2dec: combinational balance → dollars/cents split.

Test Plan:
1. Reset, coin quarter, item 1 (20¢) → dollars=0, cents=25; vend_valid with vend_item=1; next cycle change_valid with change_cents=5; then IDLE with cents=0.
2. Dime, select item 3 (40¢) → sel_reject and red pulse, balance stays 10; refund_req → change_valid with change_cents=10 and blue pulse.
3. Twenty quarters (500), then a nickel → coin_reject, dollars=5, cents=0; item 0 → vend, change_cents=490.
4. In CREDIT at 25¢, coin_valid, sel_valid item 0 and refund_req together → REFUND with change_cents=25, coin_reject, no vend.
5. Exact-price case: two dimes, item 1 → vend_valid, then IDLE with no change_valid; a coin during VEND → coin_reject.
6. With VM_INVENTORY_EN, STOCK_INIT=3: buy item 2 three times with exact change → sold_out[2]=1; a fourth buy with 30¢ → sel_reject, balance stays 30.
